// File: rtl/pipe_pkg.sv
// Shared widths and bundle layouts for the pipeline-stage registers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

   // Per-boundary bundle widths
   localparam int IFID_CTRL_W  = 1;    // no control fields yet; one spare bit keeps the vector legal
   localparam int IFID_DATA_W  = 96;   // Instr, PC, PCPlus4
   localparam int IDEX_CTRL_W  = 10;
   localparam int IDEX_DATA_W  = 165;
   localparam int EXMEM_CTRL_W = 4;    // RegWrite, MemWrite, ResultSrc
   localparam int EXMEM_DATA_W = 101;  // ALUResult, WriteData, Rd, PCPlus4
   localparam int MEMWB_CTRL_W = 3;    // RegWrite, ResultSrc
   localparam int MEMWB_DATA_W = 101;  // ALUResult, ReadData, Rd, PCPlus4

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       alu_src;
      logic       branch;
      logic       jump;
      logic [2:0] alu_control;
      logic [1:0] result_src;
   } idex_ctrl_t;

   typedef struct packed {
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm_ext;
      logic [31:0] pc;
      logic [31:0] pc_plus4;
      logic [4:0]  rd;
   } idex_data_t;

   // All write enables low: what a bubble looks like to a legacy consumer
   localparam idex_ctrl_t CTRL_NOP = '0;

   // Number of beats held given the two entry valid bits
   function automatic logic [1:0] occ_count(input logic v_main, input logic v_skid);
      return {1'b0, v_main} + {1'b0, v_skid};
   endfunction

endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: valid + control + data with load and clear-valid/ctrl.
// Latency: load visible one clock after the edge that samples it.
// Backpressure: none internally; the parent decides when to load or clear.
module pipe_entry
   import pipe_pkg::*;
#(
   parameter int CTRL_W = IDEX_CTRL_W,
   parameter int DATA_W = IDEX_DATA_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] load_ctrl,
   input  logic [DATA_W-1:0] load_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   // Clear wins over load so a flush beats any move; data is left stale on clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         ctrl  <= '0;
         data  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= load_ctrl;
         data  <= load_data;
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready stage register carrying a control and a data bundle, with flush.
// Latency: one clock from in_fire to out_*; full throughput when downstream is ready.
// Backpressure: SKID=0 in_ready = ~vM | out_ready (combinational); SKID=1 in_ready = ~vS (registered).
module pipe_stage_elastic
   import pipe_pkg::*;
#(
   parameter int CTRL_W = IDEX_CTRL_W,
   parameter int DATA_W = IDEX_DATA_W,
   parameter bit SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              in_fire;
   logic              v_m;
   logic [CTRL_W-1:0] ctrl_m;
   logic [DATA_W-1:0] data_m;
   logic              v_s;
   logic              ld_m;
   logic              clr_m;
   logic [CTRL_W-1:0] src_ctrl;
   logic [DATA_W-1:0] src_data;

   assign in_fire = in_valid & in_ready;

   if (SKID) begin : g_skid
      logic              advance;
      logic              ld_s;
      logic              clr_s;
      logic [CTRL_W-1:0] ctrl_s;
      logic [DATA_W-1:0] data_s;

      // M can take a new beat when it is empty or is being drained this cycle
      assign advance  = ~v_m | out_ready;
      // Older skid beat has priority into M so order is preserved
      assign src_ctrl = v_s ? ctrl_s : in_ctrl;
      assign src_data = v_s ? data_s : in_data;
      assign ld_m     = ~flush & advance & (v_s | in_fire);
      assign clr_m    = flush | (advance & ~v_s & ~in_fire);
      // S catches the incoming beat when M is stuck, or refills behind a moving S
      assign ld_s     = ~flush & in_fire & (v_s | ~advance);
      assign clr_s    = flush | (advance & v_s & ~in_fire);
      // Ready depends only on the skid flop, so no path from out_ready
      assign in_ready = ~v_s;

      pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
         .clk       (clk),
         .reset_n   (reset_n),
         .load      (ld_s),
         .clear     (clr_s),
         .load_ctrl (in_ctrl),
         .load_data (in_data),
         .valid     (v_s),
         .ctrl      (ctrl_s),
         .data      (data_s)
      );
   end else begin : g_single
      logic out_fire;

      assign out_fire = v_m & out_ready;
      assign in_ready = ~v_m | out_ready;
      assign src_ctrl = in_ctrl;
      assign src_data = in_data;
      // A simultaneous in_fire replaces M, so only an unrefilled drain empties it
      assign ld_m     = ~flush & in_fire;
      assign clr_m    = flush | (out_fire & ~in_fire);
      assign v_s      = 1'b0;
   end

   pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (ld_m),
      .clear     (clr_m),
      .load_ctrl (src_ctrl),
      .load_data (src_data),
      .valid     (v_m),
      .ctrl      (ctrl_m),
      .data      (data_m)
   );

   // ctrl_m is cleared together with v_m, so an empty stage presents a NOP
   assign out_valid = v_m;
   assign out_ctrl  = ctrl_m;
   assign out_data  = data_m;
   assign occupancy = occ_count(v_m, v_s);

endmodule
